lifo_fifo_ptr_ctrl: RTL and testbench
=====================================

Name: lifo_fifo_ptr_ctrl

Overview:
Control and pointer unit that issues the write/read strobes and addresses a small LIFO/FIFO storage datapath consumes. Accepts push/pop requests from the producer and consumer and tracks occupancy. Outputs registered pointers plus wr_inc/wr_dec/rd_inc/rd_dec pulses and full/empty/error status. Mode is selected by l_f: 1 = LIFO (stack), 0 = FIFO (queue).

Parameters:
DEPTH, 4, number of storage entries; power of two, at least 2.
AW, 2, address width; must equal log2(DEPTH).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-high
l_f  in  1  requested mode, 1=LIFO 0=FIFO
push  in  1  write request, one entry per cycle
pop  in  1  read request, one entry per cycle
err_clr  in  1  clears sticky error
wr_addr  out  AW  slot to write next
rd_addr  out  AW  slot to read next
wr_inc  out  1  pulse, write pointer incremented
wr_dec  out  1  pulse, write pointer decremented
rd_inc  out  1  pulse, read pointer incremented
rd_dec  out  1  pulse, read pointer decremented
count  out  AW+1  occupancy, 0..DEPTH
full  out  1  count==DEPTH
empty  out  1  count==0
mode  out  1  active mode register
error  out  1  sticky illegal-request flag

Behaviour:
- Reset (clk is clk; rst_n is asynchronous, active-high):
  - wr_addr=0, rd_addr=0, count=0, empty=1, full=0, error=0.
  - All strobes=0.
  - mode=l_f is sampled at the first edge after reset release. During reset, mode=0.
  - FSM is forced to S_EMPTY.
- Outputs and timing:
  - All outputs are registered.
  - An accepted request updates pointers and count, and pulses its strobes for exactly one cycle, on the same clock edge: one cycle of latency from request to outputs.
- FSM states:
  - S_EMPTY, S_PART, S_FULL, S_ERR.
  - The state is derived from the next count, except for S_ERR.
- FIFO mode (mode=0):
  - Accepted push: wr_inc=1, wr_addr+1 mod DEPTH, count+1.
  - Accepted pop: rd_inc=1, rd_addr+1 mod DEPTH, count-1.
  - Push and pop together when 0<count<DEPTH: both performed, count unchanged.
  - Push and pop together when full: both performed.
  - Push and pop together when empty: push performed, pop is illegal.
- LIFO mode (mode=1):
  - rd_addr always equals wr_addr-1 mod DEPTH, i.e. the top of stack.
  - Accepted push: wr_inc=1 and rd_inc=1, count+1.
  - Accepted pop: wr_dec=1 and rd_dec=1, count-1.
  - Push and pop in the same cycle is illegal: neither is performed.
- Illegal requests:
  - Cases: push when full (unless the FIFO both-request case above), pop when empty, simultaneous LIFO push/pop, l_f differing from mode while count!=0.
  - Effect: the illegal request is dropped, error=1 and the FSM enters S_ERR on the next edge.
  - A legal half of a simultaneous FIFO request still executes.
- S_ERR:
  - All push/pop requests are ignored; no strobes are issued.
  - err_clr=1 clears error and returns the FSM to S_EMPTY, S_PART or S_FULL according to count.
  - err_clr outside S_ERR has no effect.
- Mode change: l_f is loaded into mode only when count==0 and not in S_ERR. Pointers are reset to 0 on a mode change.
- Reset mid-operation: everything returns to reset values immediately. In-flight strobes are cleared.

Optional Feature:
Macro LFPC_ALMOST_FLAGS_EN.
- Defined: adds registered outputs almost_full (count>=DEPTH-1) and almost_empty (count<=1). Both update on the same edge as count. Reset values: almost_full=0, almost_empty=1.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
1. FIFO, 4 pushes then 4 pops -> wr_inc pulses and wr_addr 1,2,3,0, count 1..4, full=1. Pops then give rd_addr 1,2,3,0, count 3..0, empty=1, error=0.
2. LIFO, push x3 then pop x1 -> wr_addr=3, rd_addr=2 after pushes; after the pop wr_addr=2, rd_addr=1, wr_dec=rd_dec=1 for one cycle, count=2.
3. FIFO full (count=4), push+pop together -> wr_inc=rd_inc=1, count stays 4, error=0. Then a push alone -> error=1, S_ERR, no strobes.
4. Empty, pop -> error=1. Further push ignored (count=0). err_clr=1 -> error=0, S_EMPTY. Next push accepted, count=1.
5. LIFO count=2, l_f toggled to 0 -> error=1, mode stays 1. Drain and clear, l_f=0 -> mode=0, pointers=0.
6. Assert rst_n mid-burst with count=3 -> all outputs return to reset values asynchronously, no strobe glitch after release. With LFPC_ALMOST_FLAGS_EN, repeat test 1 -> almost_full=1 at count 3 and 4, almost_empty=1 at count 0 and 1.

Source files
------------

// File: rtl/lifo_fifo_ptr_ctrl_if.sv
// Request/status bundle between a producer/consumer and the LIFO/FIFO
// pointer controller. The master drives requests, the slave (controller)
// drives pointers, strobes and status.
// Optional almost_full/almost_empty members exist only when
// LFPC_ALMOST_FLAGS_EN is defined.
interface lifo_fifo_ptr_ctrl_if #(
  parameter int AW = 2
);
  logic          l_f;
  logic          push;
  logic          pop;
  logic          err_clr;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          wr_inc;
  logic          wr_dec;
  logic          rd_inc;
  logic          rd_dec;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          mode;
  logic          error;
`ifdef LFPC_ALMOST_FLAGS_EN
  logic          almost_full;
  logic          almost_empty;

  modport master (
    output l_f, push, pop, err_clr,
    input  wr_addr, rd_addr, wr_inc, wr_dec, rd_inc, rd_dec,
    input  count, full, empty, mode, error, almost_full, almost_empty
  );
  modport slave (
    input  l_f, push, pop, err_clr,
    output wr_addr, rd_addr, wr_inc, wr_dec, rd_inc, rd_dec,
    output count, full, empty, mode, error, almost_full, almost_empty
  );
`else
  modport master (
    output l_f, push, pop, err_clr,
    input  wr_addr, rd_addr, wr_inc, wr_dec, rd_inc, rd_dec,
    input  count, full, empty, mode, error
  );
  modport slave (
    input  l_f, push, pop, err_clr,
    output wr_addr, rd_addr, wr_inc, wr_dec, rd_inc, rd_dec,
    output count, full, empty, mode, error
  );
`endif
endinterface

// File: rtl/lifo_fifo_ptr_ctrl.sv
// Pointer/control unit for a small LIFO/FIFO storage array.
// Tracks occupancy, issues registered write/read pointers and one-cycle
// inc/dec strobes, and flags illegal requests with a sticky error that
// parks the controller in S_ERR until err_clr.
// Reset rst_n is asynchronous and active-high.
// Optional feature macro: LFPC_ALMOST_FLAGS_EN (adds almost_full/almost_empty).
module lifo_fifo_ptr_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic               clk,
  input logic               rst_n,
  lifo_fifo_ptr_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_EMPTY, S_PART, S_FULL, S_ERR} state_t;

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  state_t        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic          mode_q, mode_d;
  logic          err_q, err_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          wr_inc_q, wr_inc_d, wr_dec_q, wr_dec_d;
  logic          rd_inc_q, rd_inc_d, rd_dec_q, rd_dec_d;
`ifdef LFPC_ALMOST_FLAGS_EN
  logic          afull_q, afull_d, aempty_q, aempty_d;
`endif

  logic          do_push, do_pop, illegal;
  logic          eff_mode, mode_chg;
  logic [AW-1:0] base_wr, base_rd;

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // Next state: S_ERR while the sticky error holds, otherwise from next count.
  always_comb begin
    state_d = state_q;
    if (err_d)                  state_d = S_ERR;
    else if (count_d == '0)     state_d = S_EMPTY;
    else if (count_d == DEPTH_C) state_d = S_FULL;
    else                        state_d = S_PART;
  end

  // Request decode and next values of every registered output.
  always_comb begin
    do_push  = 1'b0;
    do_pop   = 1'b0;
    illegal  = 1'b0;
    mode_chg = 1'b0;
    eff_mode = mode_q;
    if (state_q != S_ERR) begin
      // Mode can only follow l_f while empty; the new mode applies to this
      // cycle's requests, starting from freshly reset pointers.
      if (count_q == '0) begin
        eff_mode = bus.l_f;
        mode_chg = (bus.l_f != mode_q);
      end else if (bus.l_f != mode_q) begin
        illegal = 1'b1;
      end
      if (eff_mode) begin
        if (bus.push && bus.pop) illegal = 1'b1;
        else if (bus.push) begin
          if (count_q == DEPTH_C) illegal = 1'b1;
          else                    do_push = 1'b1;
        end else if (bus.pop) begin
          if (count_q == '0) illegal = 1'b1;
          else               do_pop  = 1'b1;
        end
      end else begin
        if (bus.push && bus.pop) begin
          do_push = 1'b1;
          if (count_q == '0) illegal = 1'b1;
          else               do_pop  = 1'b1;
        end else if (bus.push) begin
          if (count_q == DEPTH_C) illegal = 1'b1;
          else                    do_push = 1'b1;
        end else if (bus.pop) begin
          if (count_q == '0) illegal = 1'b1;
          else               do_pop  = 1'b1;
        end
      end
    end

    // In LIFO the read pointer is the top of stack, one below wr.
    base_wr = mode_chg ? '0 : wr_q;
    base_rd = mode_chg ? (eff_mode ? '1 : '0) : rd_q;

    wr_d     = base_wr;
    rd_d     = base_rd;
    wr_inc_d = 1'b0;
    wr_dec_d = 1'b0;
    rd_inc_d = 1'b0;
    rd_dec_d = 1'b0;
    if (eff_mode) begin
      if (do_push) begin
        wr_d = base_wr + PTR_ONE;  rd_d = base_rd + PTR_ONE;
        wr_inc_d = 1'b1;           rd_inc_d = 1'b1;
      end else if (do_pop) begin
        wr_d = base_wr - PTR_ONE;  rd_d = base_rd - PTR_ONE;
        wr_dec_d = 1'b1;           rd_dec_d = 1'b1;
      end
    end else begin
      if (do_push) begin
        wr_d = base_wr + PTR_ONE;  wr_inc_d = 1'b1;
      end
      if (do_pop) begin
        rd_d = base_rd + PTR_ONE;  rd_inc_d = 1'b1;
      end
    end

    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
    else if (do_pop && !do_push) count_d = count_q - CNT_ONE;

    mode_d  = eff_mode;
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    if (state_q == S_ERR) err_d = !bus.err_clr;
    else                  err_d = illegal;
`ifdef LFPC_ALMOST_FLAGS_EN
    afull_d  = (count_d >= DEPTH_C - CNT_ONE);
    aempty_d = (count_d <= CNT_ONE);
`endif
  end

  // Output/datapath registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      wr_inc_q <= 1'b0;
      wr_dec_q <= 1'b0;
      rd_inc_q <= 1'b0;
      rd_dec_q <= 1'b0;
`ifdef LFPC_ALMOST_FLAGS_EN
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
`endif
    end else begin
      count_q  <= count_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      wr_inc_q <= wr_inc_d;
      wr_dec_q <= wr_dec_d;
      rd_inc_q <= rd_inc_d;
      rd_dec_q <= rd_dec_d;
`ifdef LFPC_ALMOST_FLAGS_EN
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
`endif
    end
  end

  assign bus.wr_addr = wr_q;
  assign bus.rd_addr = rd_q;
  assign bus.wr_inc  = wr_inc_q;
  assign bus.wr_dec  = wr_dec_q;
  assign bus.rd_inc  = rd_inc_q;
  assign bus.rd_dec  = rd_dec_q;
  assign bus.count   = count_q;
  assign bus.full    = full_q;
  assign bus.empty   = empty_q;
  assign bus.mode    = mode_q;
  assign bus.error   = err_q;
`ifdef LFPC_ALMOST_FLAGS_EN
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
`endif

endmodule

// File: tb/tb_lifo_fifo_ptr_ctrl.sv
// Randomized and directed bench for lifo_fifo_ptr_ctrl against an
// occupancy/pointer reference model kept in plain integers.
module tb_lifo_fifo_ptr_ctrl;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  lifo_fifo_ptr_ctrl_if #(.AW(AW)) bus();

  lifo_fifo_ptr_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_cnt, m_wr, m_rd;
  bit m_mode, m_err;
  bit m_wi, m_wd, m_ri, m_rdc;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_wr = 0; m_rd = 0; m_mode = 0; m_err = 0;
    m_wi = 0; m_wd = 0; m_ri = 0; m_rdc = 0;
  endtask

  task automatic model_step(input bit lf, input bit ps, input bit pp, input bit ec);
    bit ill, dpush, dpop;
    ill = 0; dpush = 0; dpop = 0;
    m_wi = 0; m_wd = 0; m_ri = 0; m_rdc = 0;
    if (m_err) begin
      if (ec) m_err = 0;
      return;
    end
    if (lf != m_mode) begin
      if (m_cnt == 0) begin
        m_mode = lf; m_wr = 0; m_rd = 0;
      end else ill = 1;
    end
    if (ps && pp) begin
      if (m_mode)          ill = 1;
      else if (m_cnt == 0) begin dpush = 1; ill = 1; end
      else                 begin dpush = 1; dpop = 1; end
    end else if (ps) begin
      if (m_cnt == DEPTH) ill = 1; else dpush = 1;
    end else if (pp) begin
      if (m_cnt == 0) ill = 1; else dpop = 1;
    end
    if (dpush) begin
      m_cnt++;
      m_wr = (m_wr + 1) % DEPTH;
      m_wi = 1;
      if (m_mode) m_ri = 1;
    end
    if (dpop) begin
      m_cnt--;
      if (m_mode) begin
        m_wr = (m_wr + DEPTH - 1) % DEPTH;
        m_wd = 1; m_rdc = 1;
      end else begin
        m_rd = (m_rd + 1) % DEPTH;
        m_ri = 1;
      end
    end
    m_err = ill;
  endtask

  task automatic compare_all();
    check("wr_addr", bus.wr_addr, m_wr);
    check("rd_addr", bus.rd_addr, m_mode ? (m_wr + DEPTH - 1) % DEPTH : m_rd);
    check("count",   bus.count, m_cnt);
    check("full",    bus.full,  m_cnt == DEPTH);
    check("empty",   bus.empty, m_cnt == 0);
    check("mode",    bus.mode,  m_mode);
    check("error",   bus.error, m_err);
    check("wr_inc",  bus.wr_inc, m_wi);
    check("wr_dec",  bus.wr_dec, m_wd);
    check("rd_inc",  bus.rd_inc, m_ri);
    check("rd_dec",  bus.rd_dec, m_rdc);
`ifdef LFPC_ALMOST_FLAGS_EN
    check("almost_full",  bus.almost_full,  m_cnt >= DEPTH - 1);
    check("almost_empty", bus.almost_empty, m_cnt <= 1);
`endif
  endtask

  task automatic cycle(input bit lf, input bit ps, input bit pp, input bit ec);
    bus.l_f = lf; bus.push = ps; bus.pop = pp; bus.err_clr = ec;
    @(posedge clk);
    model_step(lf, ps, pp, ec);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input bit lf);
    rst_n = 1'b1;
    bus.l_f = lf; bus.push = 0; bus.pop = 0; bus.err_clr = 0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    bit lf;
    bus.l_f = 0; bus.push = 0; bus.pop = 0; bus.err_clr = 0;

    // 1: FIFO fill and drain
    do_reset(0);
    repeat (4) cycle(0, 1, 0, 0);
    check("t1_full", bus.full, 1);
    check("t1_wr_wrap", bus.wr_addr, 0);
    repeat (4) cycle(0, 0, 1, 0);
    check("t1_empty", bus.empty, 1);
    check("t1_rd_wrap", bus.rd_addr, 0);

    // 2: LIFO push x3, pop x1
    do_reset(1);
    repeat (3) cycle(1, 1, 0, 0);
    check("t2_wr", bus.wr_addr, 3);
    check("t2_rd", bus.rd_addr, 2);
    cycle(1, 0, 1, 0);
    check("t2_wr_pop", bus.wr_addr, 2);
    check("t2_rd_pop", bus.rd_addr, 1);
    check("t2_dec", {bus.wr_dec, bus.rd_dec}, 3);
    check("t2_count", bus.count, 2);
    cycle(1, 0, 0, 0);
    check("t2_dec_pulse", {bus.wr_dec, bus.rd_dec}, 0);

    // 3: FIFO full, push+pop together, then push alone
    do_reset(0);
    repeat (4) cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0);
    check("t3_both_cnt", bus.count, 4);
    check("t3_both_err", bus.error, 0);
    cycle(0, 1, 0, 0);
    check("t3_overflow", bus.error, 1);
    cycle(0, 1, 1, 0);
    check("t3_err_nostrobe", {bus.wr_inc, bus.rd_inc}, 0);

    // 4: pop on empty, ignored push, clear, accepted push
    do_reset(0);
    cycle(0, 0, 1, 0);
    check("t4_underflow", bus.error, 1);
    cycle(0, 1, 0, 0);
    check("t4_ignored", bus.count, 0);
    cycle(0, 0, 0, 1);
    check("t4_clr", bus.error, 0);
    cycle(0, 1, 0, 0);
    check("t4_push", bus.count, 1);
    cycle(0, 0, 0, 1);
    check("t4_clr_noeffect", bus.count, 1);

    // 5: mode change blocked while occupied, allowed once drained
    do_reset(1);
    repeat (2) cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    check("t5_err", bus.error, 1);
    check("t5_mode_kept", bus.mode, 1);
    cycle(1, 0, 0, 1);
    repeat (2) cycle(1, 0, 1, 0);
    cycle(0, 0, 0, 0);
    check("t5_mode_new", bus.mode, 0);
    check("t5_ptrs", {bus.wr_addr, bus.rd_addr}, 0);

    // 6: asynchronous reset mid-burst with a push in flight
    do_reset(0);
    repeat (3) cycle(0, 1, 0, 0);
    bus.push = 1;
    #2;
    rst_n = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b0;
    bus.push = 0;
    cycle(0, 0, 0, 0);
    check("t6_no_glitch", {bus.wr_inc, bus.rd_inc, bus.wr_dec, bus.rd_dec}, 0);

    // Random traffic
    do_reset(0);
    lf = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) lf = ~lf;
      cycle(lf, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 45,
            $urandom_range(0, 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
